// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a first-word-fall-through FIFO
module uart_rx_fifo #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int FIFO_ADDR = 2
) (
    input  logic            clk,
    input  logic            i_reset_n,
    input  logic            i_rx,
    input  logic            i_s_tick,
    input  logic            i_rd,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_empty,
    output logic            o_rx_full,
    output logic            o_frame_err,
    output logic            o_overrun
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t               state;
    logic                 rx_m, rx_s;
    logic [SW-1:0]        s;
    logic [NW-1:0]        n;
    logic [DBIT-1:0]      b;
    logic [DBIT-1:0]      mem [2**FIFO_ADDR];
    logic [FIFO_ADDR-1:0] wr_ptr, rd_ptr;
    logic                 stop_done, push, pop, wr;
    assign stop_done = state == STOP && i_s_tick && s == S_STOP;
    assign push      = stop_done && rx_s;
    assign pop       = i_rd && !o_rx_empty;
    // a full FIFO still accepts the byte when the head leaves on the same edge
    assign wr        = push && (!o_rx_full || pop);
    assign o_data    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= stop_done && !rx_s;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    s     <= '0;
                end
                START: if (i_s_tick) begin
                    if (s == S_MID) begin
                        state <= rx_s ? IDLE : DATA;
                        s     <= '0;
                        n     <= '0;
                    end else s <= s + 1'b1;
                end
                DATA: if (i_s_tick) begin
                    if (s == S_BIT) begin
                        b     <= {rx_s, b[DBIT-1:1]};
                        s     <= '0;
                        state <= n == N_LAST ? STOP : DATA;
                        n     <= n == N_LAST ? n : n + 1'b1;
                    end else s <= s + 1'b1;
                end
                STOP: if (i_s_tick) begin
                    state <= s == S_STOP ? IDLE : STOP;
                    s     <= s == S_STOP ? '0 : s + 1'b1;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 2**FIFO_ADDR; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_rx_empty <= 1'b1;
            o_rx_full  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= push && !wr;
            if (wr) begin
                mem[wr_ptr] <= b;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop) begin
                o_rx_empty <= 1'b0;
                o_rx_full  <= FIFO_ADDR'(wr_ptr + 1'b1) == rd_ptr;
            end else if (pop && !wr) begin
                o_rx_full  <= 1'b0;
                o_rx_empty <= FIFO_ADDR'(rd_ptr + 1'b1) == wr_ptr;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for the UART receiver and its output FIFO
module tb_uart_rx_fifo;
    logic       clk = 1'b0, i_reset_n = 1'b0, i_rx = 1'b1, i_s_tick = 1'b0, i_rd = 1'b0;
    logic [7:0] o_data;
    logic       o_rx_empty, o_rx_full, o_frame_err, o_overrun;
    int         n_chk = 0, n_pass = 0;
    int         exp_fe = 0, got_fe = 0, exp_ov = 0, got_ov = 0;
    logic [7:0] exp_q[$];
    logic [7:0] c3 = 8'hC3;
    always #5 clk = ~clk;
    uart_rx_fifo dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_rx(i_rx), .i_s_tick(i_s_tick), .i_rd(i_rd),
        .o_data(o_data), .o_rx_empty(o_rx_empty), .o_rx_full(o_rx_full),
        .o_frame_err(o_frame_err), .o_overrun(o_overrun)
    );
    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask
    // monitor: every accepted pop is matched against the oldest expected byte
    initial forever begin
        @(negedge clk);
        #2;
        if (i_reset_n) begin
            if (o_frame_err) got_fe++;
            if (o_overrun) got_ov++;
            if (i_rd && !o_rx_empty) begin
                if (exp_q.size() == 0) chk("pop_unexpected", int'(o_data), -1);
                else chk("pop_data", int'(o_data), int'(exp_q.pop_front()));
            end
        end
    end
    task automatic tick(input logic rd);
        repeat (3) @(negedge clk);
        i_s_tick = 1'b1;
        i_rd     = rd;
        @(negedge clk);
        i_s_tick = 1'b0;
        i_rd     = 1'b0;
    endtask
    task automatic ticks(input int k);
        repeat (k) tick(1'b0);
    endtask
    // the 8th stop-bit tick is the one the receiver completes the frame on
    task automatic send(input logic [7:0] d, input logic stop, input logic rd_at_push);
        i_rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            ticks(16);
        end
        i_rx = stop;
        ticks(7);
        tick(rd_at_push);
        i_rx = 1'b1;
        ticks(20);
    endtask
    task automatic pop();
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
    endtask
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);
        chk("rst_empty", o_rx_empty, 1);
        chk("rst_full", o_rx_full, 0);
        chk("rst_fe", o_frame_err, 0);
        chk("rst_ov", o_overrun, 0);
        chk("rst_data", o_data, 0);
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        chk("a5_empty", o_rx_empty, 0);
        chk("a5_head", o_data, 8'hA5);
        pop();
        chk("a5_drained", o_rx_empty, 1);
        i_rx = 1'b0;
        ticks(3);
        i_rx = 1'b1;
        ticks(20);
        chk("glitch_empty", o_rx_empty, 1);
        chk("glitch_fe", got_fe, exp_fe);
        exp_fe++;
        send(8'h3C, 1'b0, 1'b0);
        chk("frame_fe", got_fe, exp_fe);
        chk("frame_empty", o_rx_empty, 1);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1, 1'b0);
        pop();
        chk("7e_drained", o_rx_empty, 1);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send(8'(i), 1'b1, 1'b0);
        end
        chk("fill_full", o_rx_full, 1);
        exp_ov++;
        send(8'h05, 1'b1, 1'b0);
        chk("fill_ov", got_ov, exp_ov);
        chk("fill_still_full", o_rx_full, 1);
        repeat (4) pop();
        chk("fill_drained", o_rx_empty, 1);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i * 8'h11));
            send(8'(i * 8'h11), 1'b1, 1'b0);
        end
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, 1'b1);
        chk("edge_ov", got_ov, exp_ov);
        chk("edge_full", o_rx_full, 1);
        repeat (4) pop();
        chk("edge_drained", o_rx_empty, 1);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b0);
        chk("pre_rst_empty", o_rx_empty, 0);
        i_rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 3; i++) begin
            i_rx = c3[i];
            ticks(16);
        end
        i_rx = c3[3];
        ticks(8);
        i_reset_n = 1'b0;
        i_rx      = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("mid_rst_empty", o_rx_empty, 1);
        chk("mid_rst_full", o_rx_full, 0);
        chk("mid_rst_fe", o_frame_err, 0);
        chk("mid_rst_ov", o_overrun, 0);
        chk("mid_rst_data", o_data, 0);
        i_reset_n = 1'b1;
        ticks(20);
        chk("post_rst_empty", o_rx_empty, 1);
        exp_q.push_back(8'h96);
        send(8'h96, 1'b1, 1'b0);
        chk("96_head", o_data, 8'h96);
        pop();
        chk("96_drained", o_rx_empty, 1);
        chk("final_fe", got_fe, exp_fe);
        chk("final_ov", got_ov, exp_ov);
        chk("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
